// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Pipeline register stage that carries a WIDTH-bit payload between two stages
//   with a valid/ready handshake. A 2-entry skid buffer (main + skid register)
//   makes in_ready a registered signal, so it does not depend combinationally on
//   out_ready. A synchronous flush discards every held entry, which inserts a
//   bubble. One block serves every field group (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Parameters:
//   WIDTH      payload width in bits (>= 1)
//   RESET_VAL  value loaded into both data registers on reset and on flush
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous flush, drops all held entries
//   in_valid   in   upstream presents a payload
//   in_ready   out  stage can accept a payload this cycle (registered)
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a valid payload
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  payload to downstream, driven straight from the main register
//   count      out  occupancy: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // The state encoding equals the occupancy, so count is the state register.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_data_m;
    logic [WIDTH-1:0] r_data_s;
    logic [WIDTH-1:0] w_data_m_nxt;
    logic [WIDTH-1:0] w_data_s_nxt;

    logic             w_in_fire;
    logic             w_out_fire;

    // in_ready depends only on the registered state, never on out_ready.
    assign w_in_fire  = in_valid & (r_state != StFull);
    assign w_out_fire = (r_state != StEmpty) & out_ready;

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StEmpty;
            r_data_m <= RESET_VAL;
            r_data_s <= RESET_VAL;
        end else begin
            r_state  <= w_state_nxt;
            r_data_m <= w_data_m_nxt;
            r_data_s <= w_data_s_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and data-path selection
    // -------------------------------------------------------------------------
    always_comb begin
        // Data registers hold unless an accept, skid move or flush touches them.
        w_state_nxt  = r_state;
        w_data_m_nxt = r_data_m;
        w_data_s_nxt = r_data_s;

        if (flush) begin
            // Flush outranks both handshakes; a payload offered now is dropped.
            w_state_nxt  = StEmpty;
            w_data_m_nxt = RESET_VAL;
            w_data_s_nxt = RESET_VAL;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        w_data_m_nxt = in_data;
                        w_state_nxt  = StOne;
                    end
                end
                StOne: begin
                    if (w_in_fire && w_out_fire) begin
                        w_data_m_nxt = in_data;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new payload behind the main one.
                        w_data_s_nxt = in_data;
                        w_state_nxt  = StFull;
                    end else if (w_out_fire) begin
                        // data_m keeps its last value while empty.
                        w_state_nxt  = StEmpty;
                    end
                end
                StFull: begin
                    if (w_out_fire) begin
                        w_data_m_nxt = r_data_s;
                        w_state_nxt  = StOne;
                    end
                end
                default: begin
                    // Unreachable encoding; recover to a clean empty stage.
                    w_state_nxt  = StEmpty;
                    w_data_m_nxt = RESET_VAL;
                    w_data_s_nxt = RESET_VAL;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid = (r_state != StEmpty);
        in_ready  = (r_state != StFull);
        count     = r_state;
        out_data  = r_data_m;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed and randomized bench for pipe_stage_reg at WIDTH=8, RESET_VAL=0.
// The reference model is a payload queue (at most two entries) plus the last
// value shown on out_data; it is cleared on flush and reset.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    logic [W-1:0] q[$];
    logic [W-1:0] shown = '0;

    pipe_stage_reg #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] exp_data;
        exp_data = (q.size() > 0) ? q[0] : shown;
        check({tag, "_out_valid"}, {31'b0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        check({tag, "_in_ready"},  {31'b0, in_ready},  (q.size() < 2) ? 32'd1 : 32'd0);
        check({tag, "_count"},     {30'b0, count},     q.size());
        check({tag, "_out_data"},  {24'b0, out_data},  {24'b0, exp_data});
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl);
        bit fin;
        bit fout;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        fin  = iv && (q.size() < 2);
        fout = ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (q.size() > 0) shown = q[0];
        if (fl) begin
            q.delete();
            shown = '0;
        end else begin
            if (fout) void'(q.pop_front());
            if (fin) q.push_back(id);
        end
        if (q.size() > 0) shown = q[0];
    endtask

    initial begin
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         fl;

        // ---------------- Reset state ----------------
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_count",     {30'b0, count},     32'd0);
        check("rst_out_data",  {24'b0, out_data},  32'd0);
        rst = 1'b1;

        // ---------------- Streaming ----------------
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, W'(i), 1'b1, 1'b0);
            check("stream_data",  {24'b0, out_data},  i);
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_count", {30'b0, count},     32'd1);
        end

        // ---------------- Drain to empty ----------------
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("drain_valid",    {31'b0, out_valid}, 32'd0);
        check("drain_count",    {30'b0, count},     32'd0);
        check("drain_in_ready", {31'b0, in_ready},  32'd1);
        check("drain_hold",     {24'b0, out_data},  32'h4);

        // ---------------- Backpressure / skid ----------------
        cyc(1'b1, 8'h0A, 1'b0, 1'b0);
        cyc(1'b1, 8'h0B, 1'b0, 1'b0);
        check("skid_count",    {30'b0, count},    32'd2);
        check("skid_in_ready", {31'b0, in_ready}, 32'd0);
        cyc(1'b1, 8'h0C, 1'b0, 1'b0);
        check("skid_stall_count", {30'b0, count},    32'd2);
        check("skid_stall_data",  {24'b0, out_data}, 32'hA);
        cyc(1'b1, 8'h0C, 1'b1, 1'b0);
        check("skid_out_b", {24'b0, out_data}, 32'hB);
        check("skid_cnt_b", {30'b0, count},    32'd1);
        cyc(1'b1, 8'h0C, 1'b1, 1'b0);
        check("skid_out_c", {24'b0, out_data}, 32'hC);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_model("skid_end");

        // ---------------- Flush with traffic ----------------
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        check("flush_pre_count", {30'b0, count}, 32'd2);
        cyc(1'b1, 8'h33, 1'b0, 1'b1);
        check("flush_count",    {30'b0, count},     32'd0);
        check("flush_valid",    {31'b0, out_valid}, 32'd0);
        check("flush_data",     {24'b0, out_data},  32'd0);
        check("flush_in_ready", {31'b0, in_ready},  32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("flush_no_33", {31'b0, out_valid}, 32'd0);
        // Flush while empty drops an offered payload despite in_ready=1.
        cyc(1'b1, 8'h44, 1'b1, 1'b1);
        check("flush_drop_count", {30'b0, count}, 32'd0);

        // ---------------- Asynchronous reset mid-cycle ----------------
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'h66, 1'b0, 1'b0);
        check("arst_pre_count", {30'b0, count}, 32'd2);
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready",  {31'b0, in_ready},  32'd1);
        check("arst_count",     {30'b0, count},     32'd0);
        check("arst_out_data",  {24'b0, out_data},  32'd0);
        q.delete();
        shown = '0;
        #2;
        rst = 1'b1;

        // ---------------- Random soak ----------------
        iv = 1'b0;
        id = '0;
        for (int c = 0; c < 10000; c++) begin
            // Hold the offered payload while it is stalled.
            if (!(iv && q.size() == 2)) begin
                iv = 1'($urandom_range(0, 1));
                id = W'($urandom);
            end
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 99) < 2);
            cyc(iv, id, ordy, fl);
            if (fl) iv = 1'b0;
            check_model("soak");
            check("soak_cnt_max", {31'b0, (count <= 2'd2)}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register stage that moves a WIDTH-bit payload between two pipeline stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so in_ready is a registered signal and does not combinationally depend on out_ready.
- Supports a synchronous flush that inserts a bubble.
- Replaces the per-width, hand-instanced pipeline registers with a single block usable for every field group (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
WIDTH, 32, payload width in bits (≥1)
RESET_VAL, 0, WIDTH-bit value loaded into both data registers on reset and on flush

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream presents a payload
in_ready  output  1  stage can accept a payload this cycle; registered
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  payload to downstream; driven directly from the main register
count  output  2  occupancy: 0, 1 or 2 entries held

Behaviour:
- Storage: main register (data_m, val_m) and skid register (data_s, val_s).
  - out_data=data_m, out_valid=val_m, in_ready=!val_s.
  - count=val_m+val_s.
- Handshakes:
  - in_fire=in_valid&in_ready.
  - out_fire=out_valid&out_ready.
  - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
  - out_data changes only on a cycle following an out_fire, an in_fire into an empty main register, or a flush/reset.
- Reset (rst=0, asynchronous):
  - val_m=val_s=0; data_m=data_s=RESET_VAL.
  - Therefore out_valid=0, in_ready=1, count=0, out_data=RESET_VAL.
  - Reset asserted mid-transfer drops all entries; no partial state survives.
- States, encoded by count:
  - EMPTY (0):
    - in_fire -> data_m<=in_data, ONE.
    - out_valid=0, so out_ready is ignored.
  - ONE (1):
    - in_fire&out_fire -> data_m<=in_data, stay ONE (throughput 1/cycle).
    - in_fire&!out_fire -> data_s<=in_data, FULL.
    - !in_fire&out_fire -> EMPTY; data_m retains its last value.
    - Neither -> hold.
  - FULL (2):
    - in_ready=0, so in_valid is ignored.
    - out_fire -> data_m<=data_s, val_s<=0, ONE.
    - Otherwise hold.
- Latency: a payload accepted at edge N is visible on out_data after edge N (out_valid=1 from cycle N+1). Minimum latency is 1 cycle.
- Ordering: strict FIFO; the skid entry is never presented before the main entry.
- Flush (sampled at a rising edge):
  - Clears val_m and val_s; loads RESET_VAL into data_m and data_s.
  - Has priority over in_fire and out_fire in the same cycle. A payload offered during the flush cycle is dropped, even though in_ready may read 1.
  - The cycle after a flush: count=0, in_ready=1.
- Flush and rst both active: rst wins (asynchronous).
- No payload is ever duplicated or lost except through flush or reset.
- Idle data registers do not toggle: they update only on an accept, a skid move, flush or reset.

Test Plan:
- Reset: drive rst=0 mid-cycle with count=2 -> immediately out_valid=0, in_ready=1, count=0, out_data=RESET_VAL (0) without a clock edge.
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, out_valid=1 every cycle, count=1 throughout.
- Backpressure/skid:
  - Send 0xA, 0xB with out_ready=0 -> count=2, in_ready=0 the cycle after 0xB, in_data=0xC held and not accepted.
  - Raise out_ready -> outputs 0xA, 0xB, 0xC in order with no loss or duplicate.
- Flush with traffic:
  - With count=2 (0x11, 0x22), assert flush together with in_valid=1, in_data=0x33 -> next cycle count=0, out_valid=0, out_data=RESET_VAL.
  - 0x33 is never output.
- Drain to empty: count=1, in_valid=0, out_ready=1 for one cycle -> out_valid=0 next cycle, count=0, in_ready=1.
- Random soak at WIDTH=8: random in_valid/out_ready/flush (flush 2%) for 10k cycles against a scoreboard queue cleared on flush -> exact in-order match, count==scoreboard depth every cycle, count never exceeds 2.
